gpu_qsys_key_in: RTL and testbench
==================================

Name: gpu_qsys_key_in

Overview:
- Avalon-MM slave input port that samples board push-buttons/switches into the GPU Qsys system.
- It is the read-side counterpart of the system's LED output port.
- Synchronises and debounces WIDTH external lines, then detects edges into a sticky edge-capture register.
- Drives a level interrupt to the Nios/host through a per-bit mask.

Parameters:
- WIDTH, 4, number of input lines (1..32).
- DEBOUNCE_CYCLES, 16, clk cycles an input must be stable before it is accepted (2..65535).
- EDGE_TYPE, 1, edges to capture: 0 rising, 1 falling, 2 any.
- RESET_LEVEL, 1, debounced state after reset (buttons are active-low, so idle high).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- address  in  2  word address
- chipselect  in  1  slave select
- read_n  in  1  active-low read strobe
- write_n  in  1  active-low write strobe
- writedata  in  32  write data
- readdata  out  32  read data, registered, read latency 1
- in_port  in  WIDTH  raw asynchronous button/switch inputs
- irq  out  1  level interrupt, active high

Behaviour:
- Clock and reset: clock clk; reset reset_n is asynchronous and active-low.
- Reset values:
  - readdata = 0, irq = 0.
  - Sync flops, debounced state and the previous-state register all = {WIDTH{RESET_LEVEL}}.
  - Debounce counters = 0, irqmask = 0, edgecapture = 0.
- Synchroniser: two-flop per bit. The raw edge reaches the sync output 2 cycles after in_port changes.
- Debounce, per bit:
  - If the sync value equals the debounced state, the counter clears to 0.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES-1, the debounced bit takes the sync value and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES never changes the debounced state.
  - Counter width is clog2(DEBOUNCE_CYCLES).
- Edge detect:
  - prev <= debounced every cycle.
  - rise = debounced & ~prev; fall = ~debounced & prev.
  - Select rise, fall or rise|fall according to EDGE_TYPE.
  - The detected edge is a single-cycle pulse, one cycle after the debounced change.
- Register map (32-bit words, unused upper bits read 0):
  - 0 DATA, RO: debounced state. Writes are ignored.
  - 1 reserved: reads 0, writes ignored.
  - 2 IRQMASK, RW: writedata[WIDTH-1:0].
  - 3 EDGECAPTURE: sticky; clear semantics are set by the optional feature.
- Write: occurs when chipselect && !write_n, and takes effect at that clock edge.
- Read timing: readdata <= mux(address) on every clock edge where chipselect && !read_n. Otherwise readdata holds its value. Data is valid the cycle after the strobe.
- Edgecapture set/clear priority: if an edge and a clear hit the same bit in the same cycle, the set wins and the bit stays 1.
- irq is registered: irq <= |(edgecapture & irqmask). It asserts 1 cycle after a captured bit becomes 1, provided that bit is masked in.
- Reset mid-debounce: the counter is discarded and the state returns to RESET_LEVEL. No edge is captured on reset release.

Optional Feature:
- Macro: GPU_KEY_BIT_CLEAR_EN.
- Defined: a write to address 3 clears only the bits set in writedata[WIDTH-1:0] (write-1-to-clear).
- Undefined: any write to address 3 clears all edgecapture bits, regardless of data.
- The set-wins-over-clear priority applies in both modes.

Decomposition:
- Package gpu_qsys_key_pkg:
  - Register address constants: ADDR_DATA=0, ADDR_IRQMASK=2, ADDR_EDGECAP=3.
  - EDGE_TYPE encodings: EDGE_RISE=0, EDGE_FALL=1, EDGE_ANY=2.
- Sub-module gpu_qsys_key_debounce: one bit wide, containing the synchroniser and the stability counter. It is instantiated WIDTH times via generate.
- The top level holds the edge detect, the registers, the read mux and irq.

Test Plan:
- Reset, then read address 0 -> readdata=0x0000000F (WIDTH=4, RESET_LEVEL=1); address 2 and address 3 both read 0; irq=0.
- Falling edge (EDGE_TYPE=1): in_port[1] 1->0 held 20 cycles, DEBOUNCE_CYCLES=16.
  - Debounced bit 1 falls exactly 2+16 cycles after the change.
  - Edgecapture then reads 0x2.
  - With IRQMASK=0x2, irq rises 1 cycle after the capture bit sets. With IRQMASK=0, irq stays 0.
- Glitch: in_port[0] low for 10 cycles then high again -> DATA stays 0xF, edgecapture stays 0, irq stays 0.
- Clear, with GPU_KEY_BIT_CLEAR_EN defined: edgecapture=0x6, write 0x2 to address 3 -> reads 0x4; irq follows IRQMASK.
- Clear, without the macro: edgecapture=0x6, write 0x2 to address 3 -> reads 0x0.
- Collision: a clear write to bit 1 lands in the same cycle as a new bit-1 edge pulse -> edgecapture bit 1 remains 1.
- Reset mid-operation: assert reset_n=0 while bit 2 is mid-debounce with edgecapture=0x1.
  - All registers return to reset values and irq drops asynchronously.
  - After release, with in_port held at 0xF, no edges are captured for 100 cycles.

Source files
------------

// File: rtl/gpu_qsys_key_pkg.sv
// Shared constants for the GPU Qsys key/switch input port:
// register word addresses, edge-type encodings and a counter-width helper.
package gpu_qsys_key_pkg;

   localparam logic [1:0] ADDR_DATA    = 2'd0;
   localparam logic [1:0] ADDR_RSVD    = 2'd1;
   localparam logic [1:0] ADDR_IRQMASK = 2'd2;
   localparam logic [1:0] ADDR_EDGECAP = 2'd3;

   localparam int EDGE_RISE = 0;
   localparam int EDGE_FALL = 1;
   localparam int EDGE_ANY  = 2;

   // The stability counter only needs to reach cycles-1; keep at least one bit.
   function automatic int count_width(input int cycles);
      return (cycles > 2) ? $clog2(cycles) : 1;
   endfunction

endpackage

// File: rtl/gpu_qsys_key_debounce.sv
// One-bit two-flop synchroniser followed by a stability counter; the debounced
// output only follows the synchronised input after DEBOUNCE_CYCLES of disagreement.
module gpu_qsys_key_debounce #(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter bit RESET_LEVEL     = 1'b1
) (
   input  logic clk,
   input  logic reset_n,
   input  logic raw,
   output logic debounced
);
   import gpu_qsys_key_pkg::*;

   localparam int CW = count_width(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync_meta;
   logic          sync_out;
   logic [CW-1:0] cnt;

   // The sync flops reset to the idle level so releasing reset never looks like an edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_meta <= RESET_LEVEL;
         sync_out  <= RESET_LEVEL;
      end else begin
         sync_meta <= raw;
         sync_out  <= sync_meta;
      end
   end

   // Any agreement with the current state restarts the count, so short glitches are discarded.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt       <= '0;
         debounced <= RESET_LEVEL;
      end else if (sync_out == debounced) begin
         cnt <= '0;
      end else if (cnt == CNT_MAX) begin
         cnt       <= '0;
         debounced <= sync_out;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/gpu_qsys_key_in.sv
// Avalon-MM key/switch input port: debounced DATA, IRQMASK and sticky EDGECAPTURE with level irq.
// Define GPU_KEY_BIT_CLEAR_EN for write-1-to-clear EDGECAPTURE; otherwise any write clears all bits.
module gpu_qsys_key_in #(
   parameter int WIDTH           = 4,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int EDGE_TYPE       = 1,
   parameter int RESET_LEVEL     = 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             read_n,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   input  logic [WIDTH-1:0] in_port,
   output logic             irq
);
   import gpu_qsys_key_pkg::*;

   localparam bit               RST_BIT   = (RESET_LEVEL != 0);
   localparam logic [WIDTH-1:0] RESET_VEC = {WIDTH{RST_BIT}};

   logic [WIDTH-1:0] db;
   logic [WIDTH-1:0] prev;
   logic [WIDTH-1:0] rise;
   logic [WIDTH-1:0] fall;
   logic [WIDTH-1:0] edge_det;
   logic [WIDTH-1:0] irqmask;
   logic [WIDTH-1:0] edgecap;
   logic [WIDTH-1:0] clr_mask;
   logic [31:0]      rd_mux;
   logic             wr_en;
   logic             rd_en;
   logic             edgecap_wr;
   logic             unused_wdata;

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      gpu_qsys_key_debounce #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .RESET_LEVEL     (RST_BIT)
      ) u_debounce (
         .clk       (clk),
         .reset_n   (reset_n),
         .raw       (in_port[i]),
         .debounced (db[i])
      );
   end

   assign wr_en        = chipselect & ~write_n;
   assign rd_en        = chipselect & ~read_n;
   assign edgecap_wr   = wr_en && (address == ADDR_EDGECAP);
   assign unused_wdata = ^writedata;

`ifdef GPU_KEY_BIT_CLEAR_EN
   assign clr_mask = edgecap_wr ? writedata[WIDTH-1:0] : '0;
`else
   assign clr_mask = edgecap_wr ? {WIDTH{1'b1}} : '0;
`endif

   // Edge pulses come from comparing the debounced state with last cycle's copy.
   always_comb begin
      rise = db & ~prev;
      fall = ~db & prev;
      if (EDGE_TYPE == EDGE_RISE) begin
         edge_det = rise;
      end else if (EDGE_TYPE == EDGE_FALL) begin
         edge_det = fall;
      end else begin
         edge_det = rise | fall;
      end
   end

   // A new edge is OR-ed in after the clear, so a same-cycle set always survives.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         prev    <= RESET_VEC;
         irqmask <= '0;
         edgecap <= '0;
         irq     <= 1'b0;
      end else begin
         prev    <= db;
         edgecap <= (edgecap & ~clr_mask) | edge_det;
         irq     <= |(edgecap & irqmask);
         if (wr_en && (address == ADDR_IRQMASK)) begin
            irqmask <= writedata[WIDTH-1:0];
         end
      end
   end

   always_comb begin
      rd_mux = '0;
      case (address)
         ADDR_DATA:    rd_mux = 32'(db);
         ADDR_RSVD:    rd_mux = '0;
         ADDR_IRQMASK: rd_mux = 32'(irqmask);
         ADDR_EDGECAP: rd_mux = 32'(edgecap);
         default:      rd_mux = '0;
      endcase
   end

   // Read latency of one: readdata only updates on a strobed read and holds otherwise.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         readdata <= '0;
      end else if (rd_en) begin
         readdata <= rd_mux;
      end
   end

endmodule

// File: tb/tb_gpu_qsys_key_in.sv
// Directed bench for gpu_qsys_key_in: register reads go through an expected-value queue
// that is popped when readdata becomes valid; irq is checked cycle-accurately.
module tb_gpu_qsys_key_in;
   import gpu_qsys_key_pkg::*;

   localparam int WIDTH = 4;

`ifdef GPU_KEY_BIT_CLEAR_EN
   localparam logic [31:0] CLR_EXP = 32'h4;
`else
   localparam logic [31:0] CLR_EXP = 32'h0;
`endif

   logic             clk = 1'b0;
   logic             reset_n;
   logic [1:0]       address;
   logic             chipselect;
   logic             read_n;
   logic             write_n;
   logic [31:0]      writedata;
   logic [31:0]      readdata;
   logic [WIDTH-1:0] in_port;
   logic             irq;

   int          tests_run    = 0;
   int          tests_failed = 0;
   logic [31:0] exp_q[$];
   string       tag_q[$];

   gpu_qsys_key_in #(
      .WIDTH           (WIDTH),
      .DEBOUNCE_CYCLES (16),
      .EDGE_TYPE       (1),
      .RESET_LEVEL     (1)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .address    (address),
      .chipselect (chipselect),
      .read_n     (read_n),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .in_port    (in_port),
      .irq        (irq)
   );

   always #5 clk = ~clk;

   // Advance to just after the next rising edge, where outputs are sampled and inputs driven.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [1:0] addr, input logic rd, input logic wr,
                                input logic [31:0] wdata);
      address    = addr;
      chipselect = rd | wr;
      read_n     = ~rd;
      write_n    = ~wr;
      writedata  = wdata;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      tests_run++;
      assert (observed === expected) else begin
         tests_failed++;
         $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
      end
   endtask

   task automatic readReg(input logic [1:0] addr, input logic [31:0] expected, input string tag);
      logic [31:0] exp_val;
      string       exp_tag;
      applyStimulus(addr, 1'b1, 1'b0, 32'h0);
      exp_q.push_back(expected);
      tag_q.push_back(tag);
      tick();
      applyStimulus(2'd0, 1'b0, 1'b0, 32'h0);
      exp_val = exp_q.pop_front();
      exp_tag = tag_q.pop_front();
      checkOutput(exp_tag, readdata, exp_val);
   endtask

   task automatic writeReg(input logic [1:0] addr, input logic [31:0] data);
      applyStimulus(addr, 1'b0, 1'b1, data);
      tick();
      applyStimulus(2'd0, 1'b0, 1'b0, 32'h0);
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int irq_seen;
      applyStimulus(2'd0, 1'b0, 1'b0, 32'h0);
      in_port = 4'hF;
      reset_n = 1'b0;
      repeat (3) tick();
      checkOutput("reset_irq", 32'(irq), 32'h0);
      checkOutput("reset_readdata", readdata, 32'h0);
      reset_n = 1'b1;
      tick();

      readReg(ADDR_DATA, 32'hF, "data_after_reset");
      readReg(ADDR_RSVD, 32'h0, "rsvd_read");
      readReg(ADDR_IRQMASK, 32'h0, "irqmask_reset");
      readReg(ADDR_EDGECAP, 32'h0, "edgecap_reset");
      writeReg(ADDR_DATA, 32'h0);
      writeReg(ADDR_RSVD, 32'hFFFF_FFFF);
      readReg(ADDR_DATA, 32'hF, "data_write_ignored");
      readReg(ADDR_RSVD, 32'h0, "rsvd_write_ignored");

      // Glitch shorter than the debounce window
      in_port = 4'hE;
      repeat (10) tick();
      in_port = 4'hF;
      irq_seen = 0;
      repeat (30) begin
         tick();
         if (irq) irq_seen++;
      end
      readReg(ADDR_DATA, 32'hF, "glitch_data");
      readReg(ADDR_EDGECAP, 32'h0, "glitch_edgecap");
      checkOutput("glitch_irq", irq_seen, 32'h0);

      // Falling edge on bit 1 with irq masked off; debounced state moves at edge 18
      in_port = 4'hD;
      irq_seen = 0;
      for (int k = 1; k <= 20; k++) begin
         readReg(ADDR_DATA, (k >= 19) ? 32'hD : 32'hF, $sformatf("fall_timing_k%0d", k));
         if (irq) irq_seen++;
      end
      repeat (2) tick();
      readReg(ADDR_EDGECAP, 32'h2, "fall_edgecap");
      checkOutput("mask0_irq", irq_seen, 32'h0);

      // Rising edge must not be captured in falling-edge mode
      in_port = 4'hF;
      repeat (25) tick();
      readReg(ADDR_DATA, 32'hF, "rise_data");
      readReg(ADDR_EDGECAP, 32'h2, "rise_not_captured");

      writeReg(ADDR_EDGECAP, 32'hF);
      readReg(ADDR_EDGECAP, 32'h0, "clear_all");
      writeReg(ADDR_IRQMASK, 32'h2);
      readReg(ADDR_IRQMASK, 32'h2, "irqmask_rw");

      // Masked falling edge: capture at edge 19, irq at edge 20
      in_port = 4'hD;
      for (int k = 1; k <= 22; k++) begin
         tick();
         checkOutput($sformatf("irq_timing_k%0d", k), 32'(irq), (k >= 20) ? 32'h1 : 32'h0);
      end
      readReg(ADDR_EDGECAP, 32'h2, "fall_edgecap_masked");

      // Build edgecapture = 0x6, then clear bit 1
      in_port = 4'h9;
      repeat (25) tick();
      readReg(ADDR_EDGECAP, 32'h6, "edgecap_six");
      writeReg(ADDR_EDGECAP, 32'h2);
      readReg(ADDR_EDGECAP, CLR_EXP, "clear_bit1");
      checkOutput("irq_after_clear", 32'(irq), 32'h0);
      writeReg(ADDR_IRQMASK, 32'h4);
      tick();
      checkOutput("irq_follows_mask", 32'(irq), (CLR_EXP != 0) ? 32'h1 : 32'h0);

      // Clear write lands in the same cycle as a new bit-1 edge pulse
      in_port = 4'hF;
      repeat (25) tick();
      writeReg(ADDR_EDGECAP, 32'hF);
      readReg(ADDR_EDGECAP, 32'h0, "pre_collision_clear");
      in_port = 4'hD;
      repeat (18) tick();
      writeReg(ADDR_EDGECAP, 32'h2);
      readReg(ADDR_EDGECAP, 32'h2, "collision_set_wins");

      // Reset while bit 2 is mid-debounce and edgecapture = 0x1
      in_port = 4'hF;
      repeat (25) tick();
      writeReg(ADDR_EDGECAP, 32'hF);
      writeReg(ADDR_IRQMASK, 32'h1);
      in_port = 4'hE;
      repeat (25) tick();
      readReg(ADDR_EDGECAP, 32'h1, "edgecap_one");
      checkOutput("irq_before_reset", 32'(irq), 32'h1);
      in_port = 4'hA;
      repeat (8) tick();
      reset_n = 1'b0;
      #1;
      checkOutput("irq_async_drop", 32'(irq), 32'h0);
      checkOutput("readdata_async_reset", readdata, 32'h0);
      in_port = 4'hF;
      repeat (3) tick();
      reset_n = 1'b1;
      tick();
      readReg(ADDR_DATA, 32'hF, "data_after_midreset");
      readReg(ADDR_IRQMASK, 32'h0, "irqmask_after_midreset");
      readReg(ADDR_EDGECAP, 32'h0, "edgecap_after_midreset");
      writeReg(ADDR_IRQMASK, 32'hF);
      irq_seen = 0;
      repeat (100) begin
         tick();
         if (irq) irq_seen++;
      end
      readReg(ADDR_EDGECAP, 32'h0, "no_edge_after_reset");
      checkOutput("no_irq_after_reset", irq_seen, 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
